// File: rtl/adbg_biu_burst_ctrl.sv
// Purpose : splits one debug burst command into single-word BIU transfers, auto-incrementing the address.
// Latency : a read issues its first strobe 1 cycle after accept; a write issues it 1 cycle after its first wdat beat;
//           done pulses 1 cycle after the last word.
// Backpress: cmd_ready only in IDLE; wdat_valid/rdat_ready stall the burst; biu_rdy stretches both strobe and wait.
//
// Ports:
//   biu_clk/biu_rst_n        clock, async active-low reset
//   cmd_*                    burst command (rw, start addr, word size, word count) with valid/ready
//   abort                    level abort request
//   wdat_* / rdat_*          write/read data streams (valid/ready)
//   done/err/aborted         end-of-burst pulse and sticky status
//   words_done               error-free words in the current/last burst
//   biu_*                    single-word BIU handshake
//   crc                      running CRC-32 of data words (only when ADBG_BURST_CRC_EN is defined)
// Build option: define ADBG_BURST_CRC_EN to enable the data CRC; otherwise crc is the constant 32'hFFFFFFFF.
module adbg_biu_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  biu_clk,
    input  logic                  biu_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_word_size,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  abort,
    input  logic                  wdat_valid,
    output logic                  wdat_ready,
    input  logic [DATA_WIDTH-1:0] wdat,
    output logic                  rdat_valid,
    input  logic                  rdat_ready,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  done,
    output logic                  err,
    output logic                  aborted,
    output logic [CNT_WIDTH-1:0]  words_done,
    output logic                  biu_strb,
    output logic                  biu_rw,
    output logic [ADDR_WIDTH-1:0] biu_addr,
    output logic [DATA_WIDTH-1:0] biu_di,
    output logic [3:0]            biu_word_size,
    input  logic [DATA_WIDTH-1:0] biu_do,
    input  logic                  biu_rdy,
    input  logic                  biu_err,
    output logic [31:0]           crc
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_RDOUT, ST_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic                   rw_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [3:0]             size_q;
    logic [CNT_WIDTH-1:0]   remaining;
    logic                   abort_pend;

    logic accept, latch_wdat, complete, capture, set_err, set_abort;
    logic abort_hit;
    logic [3:0] size_norm;

    // Anything other than 1/2/4 bytes is treated as a full word.
    assign size_norm = (cmd_word_size == 4'd1 || cmd_word_size == 4'd2 || cmd_word_size == 4'd4)
                       ? cmd_word_size : 4'd4;

    // An abort seen while a transfer is in flight is remembered until that transfer completes.
    assign abort_hit = abort || abort_pend;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        latch_wdat = 1'b0;
        complete   = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        set_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_count == '0) state_nxt = ST_DONE;
                    else if (cmd_rw)     state_nxt = ST_ISSUE;
                    else                 state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    set_abort = 1'b1;
                    state_nxt = ST_DONE;
                end else if (wdat_valid) begin
                    latch_wdat = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (biu_rdy) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (biu_rdy) begin
                    if (biu_err) begin
                        set_err   = 1'b1;
                        set_abort = abort_hit;
                        state_nxt = ST_DONE;
                    end else begin
                        complete = 1'b1;
                        if (abort_hit) begin
                            set_abort = 1'b1;
                            state_nxt = ST_DONE;
                        end else if (rw_q) begin
                            capture   = 1'b1;
                            state_nxt = ST_RDOUT;
                        end else if (remaining == CNT_ONE) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_FETCH;
                        end
                    end
                end
            end
            ST_RDOUT: begin
                if (abort) begin
                    set_abort = 1'b1;
                    state_nxt = ST_DONE;
                end else if (rdat_ready) begin
                    state_nxt = (remaining == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge biu_clk or negedge biu_rst_n) begin
        if (!biu_rst_n) begin
            state      <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            remaining  <= '0;
            abort_pend <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
            words_done <= '0;
            biu_di     <= '0;
            rdat       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rw_q       <= cmd_rw;
                addr_q     <= cmd_addr;
                size_q     <= size_norm;
                remaining  <= cmd_count;
                abort_pend <= 1'b0;
                err        <= 1'b0;
                aborted    <= 1'b0;
                words_done <= '0;
            end else if (abort && (state == ST_ISSUE || state == ST_WAIT)) begin
                abort_pend <= 1'b1;
            end
            if (latch_wdat) biu_di <= wdat;
            if (capture)    rdat   <= biu_do;
            if (set_err)    err     <= 1'b1;
            if (set_abort)  aborted <= 1'b1;
            if (complete) begin
                words_done <= words_done + CNT_ONE;
                if (remaining != '0) remaining <= remaining - CNT_ONE;
                addr_q <= addr_q + {{(ADDR_WIDTH-4){1'b0}}, size_q};
            end
        end
    end

    assign cmd_ready     = (state == ST_IDLE);
    assign wdat_ready    = (state == ST_FETCH);
    assign rdat_valid    = (state == ST_RDOUT);
    assign done          = (state == ST_DONE);
    assign biu_strb      = (state == ST_ISSUE);
    assign biu_rw        = rw_q;
    assign biu_addr      = addr_q;
    assign biu_word_size = size_q;

`ifdef ADBG_BURST_CRC_EN
    // CRC-32, reflected polynomial, LSB first, no final XOR.
    function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 32; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    logic [31:0] crc_q;

    always_ff @(posedge biu_clk or negedge biu_rst_n) begin
        if (!biu_rst_n) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (accept) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (latch_wdat) begin
            crc_q <= crc32_word(crc_q, wdat);
        end else if (capture) begin
            crc_q <= crc32_word(crc_q, biu_do);
        end
    end

    assign crc = crc_q;
`else
    assign crc = 32'hFFFFFFFF;
`endif

endmodule
